// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, default line settings
// and the baud-tick divisor calculation.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEFAULT_CLK_FREQ  = 100_000_000;
    localparam int DEFAULT_BAUD_RATE = 9600;

    // Rounded clk cycles per oversampling tick.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int ticks);
        int den;
        den = baud_rate * ticks;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with registered read data.
// Status ports (empty/full/overflow) exist only when UART_RX_STATUS_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
`ifdef UART_RX_STATUS_EN
    ,
    output logic             empty,
    output logic             full,
    output logic             overflow
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             is_empty;
    logic             is_full;
    logic             do_rd;
    logic             do_wr;

    // Extra pointer MSB tells a full ring apart from an empty one.
    assign is_empty = (wptr == rptr);
    assign is_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_rd    = rd_en && !is_empty;
    assign do_wr    = wr_en && (!is_full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end

`ifdef UART_RX_STATUS_EN
    assign empty    = is_empty;
    assign full     = is_full;
    assign overflow = wr_en && !do_wr;
`endif

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled async serial receiver feeding a small FIFO popped via rd_en.
// Define UART_RX_STATUS_EN to add rx_empty, rx_full and sticky frame_err outputs.
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SAMPLING_TICKS = 16,
    parameter int STOP_BITS      = 1,
    parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE      = DEFAULT_BAUD_RATE,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic [WIDTH-1:0] d_out,
    input  logic             rd_en
`ifdef UART_RX_STATUS_EN
    ,
    output logic             rx_empty,
    output logic             rx_full,
    output logic             frame_err
`endif
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, SAMPLING_TICKS);
    localparam int CW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(SAMPLING_TICKS);
    localparam int NW  = $clog2(WIDTH + STOP_BITS);

    localparam logic [CW-1:0] DIV_M1      = CW'(DIV - 1);
    localparam logic [SW-1:0] S_MID       = SW'(SAMPLING_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_END       = SW'(SAMPLING_TICKS - 1);
    localparam logic [NW-1:0] N_DATA_LAST = NW'(WIDTH - 1);
    localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);

    logic             rx_meta, rx_s;
    logic [CW-1:0]    tick_cnt;
    logic             tick;
    logic [1:0]       state;
    logic [SW-1:0]    s_cnt;
    logic [NW-1:0]    n_cnt;
    logic [WIDTH-1:0] shreg;
    logic             armed;
    logic             push;
    logic             data_smp;
    logic             stop_smp;

    // Two-flop synchronizer; reset high so the idle line is not seen as a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (tick_cnt == DIV_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    assign data_smp = (state == ST_DATA) && tick && (s_cnt == S_END);
    assign stop_smp = (state == ST_STOP) && tick && (s_cnt == S_END);

    // armed blocks a new start after a frame error until the line returns high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            armed <= 1'b1;
            push  <= 1'b0;
        end else begin
            push <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_s) armed <= 1'b1;
                    else if (armed) begin
                        state <= ST_START;
                        s_cnt <= '0;
                    end
                end
                ST_START: if (tick) begin
                    if (s_cnt == S_MID) begin
                        if (!rx_s) begin
                            state <= ST_DATA;
                            s_cnt <= '0;
                            n_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                ST_DATA: if (tick) begin
                    if (s_cnt == S_END) begin
                        s_cnt <= '0;
                        if (n_cnt == N_DATA_LAST) begin
                            state <= ST_STOP;
                            n_cnt <= '0;
                        end else begin
                            n_cnt <= n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                ST_STOP: if (tick) begin
                    if (s_cnt == S_END) begin
                        s_cnt <= '0;
                        if (!rx_s) begin
                            state <= ST_IDLE;
                            armed <= 1'b0;
                        end else if (n_cnt == N_STOP_LAST) begin
                            state <= ST_IDLE;
                            push  <= 1'b1;
                        end else begin
                            n_cnt <= n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // LSB arrives first, so each new bit enters at the MSB and shifts down.
    always_ff @(posedge clk) begin
        if (data_smp) shreg <= {rx_s, shreg[WIDTH-1:1]};
    end

`ifdef UART_RX_STATUS_EN
    logic frm_err_p;
    logic overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err_p <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frm_err_p <= stop_smp && !rx_s;
            if (frm_err_p || overflow)  frame_err <= 1'b1;
            else if (rd_en && !rx_empty) frame_err <= 1'b0;
        end
    end
`endif

    uart_rx_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (shreg),
        .rd_en   (rd_en),
        .rd_data (d_out)
`ifdef UART_RX_STATUS_EN
        ,
        .empty   (rx_empty),
        .full    (rx_full),
        .overflow(overflow)
`endif
    );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, single/second byte, glitch, framing error, overflow.
// Runs at a fast baud (4 clk per tick, 64 clk per bit) to keep simulation short.
module tb_uart_rx;

    localparam int  CLK_FREQ  = 100_000_000;
    localparam int  BAUD_RATE = 1_562_500;
    localparam time BIT       = 640ns;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] d_out;
`ifdef UART_RX_STATUS_EN
    logic       rx_empty, rx_full, frame_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5ns clk = ~clk;

    uart_rx #(
        .WIDTH(8),
        .SAMPLING_TICKS(16),
        .STOP_BITS(1),
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .FIFO_DEPTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .d_out    (d_out),
        .rd_en    (rd_en)
`ifdef UART_RX_STATUS_EN
        ,
        .rx_empty (rx_empty),
        .rx_full  (rx_full),
        .frame_err(frame_err)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #BIT;
        end
        rx = stop_val;
        #BIT;
        rx = 1'b1;
        #(2 * BIT);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #200ns;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_dout", d_out, 8'h00);
`ifdef UART_RX_STATUS_EN
        check("reset_empty", {7'd0, rx_empty}, 8'h01);
`endif
        pop();
        check("pop_empty_after_reset", d_out, 8'h00);

        send_byte(8'hA5, 1'b1);
        pop();
        check("single_byte", d_out, 8'hA5);
        repeat (10) @(negedge clk);
        check("single_byte_hold", d_out, 8'hA5);

        send_byte(8'h3C, 1'b1);
        pop();
        check("second_byte", d_out, 8'h3C);
        pop();
        check("pop_on_empty_holds", d_out, 8'h3C);

        rx = 1'b0;
        #200ns;
        rx = 1'b1;
        #(4 * BIT);
        pop();
        check("glitch_rejected", d_out, 8'h3C);

        send_byte(8'h55, 1'b0);
        pop();
        check("frame_error_discard", d_out, 8'h3C);
`ifdef UART_RX_STATUS_EN
        check("frame_err_set", {7'd0, frame_err}, 8'h01);
        check("empty_after_frame_err", {7'd0, rx_empty}, 8'h01);
`endif

        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
`ifdef UART_RX_STATUS_EN
        check("full_after_overflow", {7'd0, rx_full}, 8'h01);
`endif
        for (int i = 1; i <= 8; i++) begin
            pop();
            check($sformatf("overflow_pop%0d", i), d_out, 8'(i));
`ifdef UART_RX_STATUS_EN
            if (i == 1) check("frame_err_cleared", {7'd0, frame_err}, 8'h00);
`endif
        end
        pop();
        check("ninth_byte_lost", d_out, 8'h08);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 by default, LSB first, 16x oversampling, built-in baud tick generator.
- Received bytes are pushed into a small internal FIFO; the host pops them with a single-cycle rd_en pulse.
- d_out is a registered read port that holds the last popped byte.
- Sits between the board RX pin and a host/bus register block.

Parameters:
- WIDTH, 8, data bits per frame and FIFO word width.
- SAMPLING_TICKS, 16, oversampling ticks per bit; must be even and ≥4.
- STOP_BITS, 1, number of stop bits checked (1 or 2).
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 9600, line baud rate.
- FIFO_DEPTH, 8, receive FIFO entries; power of 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- d_out  output  WIDTH  last byte popped from FIFO (registered).
- rd_en  input  1  pop request, sampled on posedge clk.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Reset clears:
  - d_out=0, FIFO empty (pointers 0), FSM=IDLE;
  - tick counter=0, synchronizer flops=1.
- Synchronizer: rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Tick generator:
  - DIV = round(CLK_FREQ/(BAUD_RATE*SAMPLING_TICKS)), giving 651 at defaults.
  - A free-running counter emits a 1-cycle tick when it reaches DIV-1, then wraps to 0.
- FSM states: IDLE, START, DATA, STOP. Per-state tick count s_cnt; bit index n_cnt.
- IDLE: synchronized rx==0 -> START, s_cnt=0.
- START: on the tick where s_cnt==SAMPLING_TICKS/2-1 (bit mid-point), sample rx:
  - rx==0 -> DATA, s_cnt=0, n_cnt=0;
  - rx==1 -> IDLE (glitch rejected).
- DATA:
  - Every SAMPLING_TICKS ticks (s_cnt==SAMPLING_TICKS-1), shift rx into the MSB of a shift register (LSB-first assembly) and increment n_cnt.
  - After WIDTH bits -> STOP.
- STOP:
  - Sample rx at the middle of each of the STOP_BITS stop bits, i.e. every SAMPLING_TICKS ticks.
  - All samples high -> write the byte into the FIFO in the cycle after the last sample, then IDLE.
  - Any sample low -> frame error: byte discarded, return to IDLE. IDLE re-arms only once rx is seen high again (no false start on a break).
- Latency: the byte is in the FIFO about 0.5 bit-time before the end of the final stop bit.
- FIFO write while full: new byte dropped; FIFO contents unchanged.
- Read:
  - rd_en=1 and FIFO not empty -> on that edge d_out<=head and the read pointer advances; d_out is valid the cycle after the rd_en edge and holds until the next successful pop.
  - rd_en while empty -> ignored; d_out holds.
  - A level-high rd_en pops one entry per cycle.
- Simultaneous push and pop: both performed in the same cycle; occupancy unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. Pointers wrap modulo 2*FIFO_DEPTH.
- Reset mid-frame: frame aborted; FIFO contents lost.

Optional Feature:
- Macro UART_RX_STATUS_EN.
- Defined: three extra output ports:
  - rx_empty (1 = FIFO empty);
  - rx_full (1 = FIFO full);
  - frame_err (sticky; set on bad stop bit or on overflow drop, cleared by a pop or by reset).
- Undefined: these ports and the sticky logic are absent; core behaviour is identical.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (IDLE/START/DATA/STOP);
  - a divisor calculation function;
  - default CLK_FREQ and BAUD_RATE constants.
- Natural sub-module: uart_rx_fifo (synchronous FIFO with registered read data, full/empty flags).
- The tick generator and FSM stay inline in uart_rx.

Test Plan:
- Reset: rst_n=0 for 200 ns, then high -> d_out=0x00; FIFO empty; rd_en pulse leaves d_out=0x00.
- Single byte: send 0xA5 at 104166 ns/bit, wait 200 µs, 1-cycle rd_en -> d_out=0xA5 and holds.
- Second byte: send 0x3C, then rd_en pulse -> d_out=0x3C; a further rd_en on the now-empty FIFO leaves d_out=0x3C.
- Glitch: rx low for 3 µs (under half a bit) -> no byte written; FIFO stays empty.
- Framing error: send 0x55 with the stop bit driven low -> byte discarded; frame_err=1 when UART_RX_STATUS_EN is defined.
- Overflow: send FIFO_DEPTH+1 bytes 0x01..0x09 without reading, then pop 8 times -> d_out sequence 0x01..0x08; 0x09 lost.
